bram_stream_reader: RTL and testbench
=====================================

BRAM_STREAM_READER -- requirements
Module: bram_stream_reader

Interface
REQ-001 Parameter RAM_WIDTH, default 32, RAM data word width in bits.
REQ-002 Parameter ADDR_LINES, default 4, RAM address width; RAM_DEPTH = 2^ADDR_LINES.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset: clk_i (input, 1, rising-edge clock) and rst_i (input, 1, synchronous active-high reset).
REQ-004 start_i  input  1  request pulse; sampled only in IDLE.
REQ-005 base_addr_i  input  ADDR_LINES  first RAM address; captured with start_i.
REQ-006 len_i  input  ADDR_LINES+1  number of words to read, 0..2*RAM_DEPTH-1; captured with start_i.
REQ-007 busy_o  output  1  high whenever state is not IDLE.
REQ-008 done_o  output  1  one-cycle pulse at the end of a transfer.
REQ-009 ram_en_o  output  1  RAM port enable; one read is issued per cycle it is high.
REQ-010 ram_addr_o  output  ADDR_LINES  RAM read address.
REQ-011 ram_regce_o  output  1  RAM output-register enable.
REQ-012 ram_rstn_o  output  1  RAM output reset, active-low; driven as ~rst_i.
REQ-013 ram_dout_i  input  RAM_WIDTH  RAM registered read data.
REQ-014 m_valid_o / m_ready_i / m_data_o (RAM_WIDTH) / m_last_o form a stream master; a beat transfers when valid and ready are both high.

Function
REQ-015 The RAM SHALL be treated as a 2-cycle read: ram_en_o in cycle t, ram_regce_o in cycle t+1, and data valid on ram_dout_i in cycle t+2.
REQ-016 ram_regce_o SHALL equal ram_en_o delayed by one cycle, and a capture strobe SHALL equal ram_en_o delayed by two cycles.
REQ-017 A 4-entry FIFO SHALL capture ram_dout_i on the capture strobe and drive m_data_o from its head.
REQ-018 m_valid_o SHALL equal FIFO not-empty.
REQ-019 Credit rule: a read SHALL be issued only while in-flight reads (max 3) plus FIFO occupancy is less than 4, so the FIFO never overflows and ram_dout_i is never lost.
REQ-020 Addresses SHALL be base_addr_i, base+1, ..., computed modulo RAM_DEPTH (wrap from RAM_DEPTH-1 to 0); a len_i greater than RAM_DEPTH re-reads wrapped addresses.
REQ-021 States SHALL be IDLE, ISSUE, DRAIN and FLUSH.
  - IDLE -> ISSUE on start_i with len_i > 0.
  - ISSUE -> DRAIN in the cycle the last read is issued.
  - DRAIN -> IDLE on the handshake of the last beat, which SHALL pulse done_o in the same cycle.
REQ-022 start_i with len_i = 0 SHALL pulse done_o in the next cycle, emit no beats and issue no reads.
REQ-023 start_i outside IDLE SHALL be ignored.
REQ-024 m_last_o SHALL be high only with the final beat of a transfer.
REQ-025 m_data_o SHALL stay stable while m_valid_o is high and m_ready_i is low.
REQ-026 Latency: start_i sampled in cycle 0 gives first ram_en_o in cycle 1 and first m_valid_o in cycle 4.
REQ-027 With m_ready_i held high the block SHALL sustain one beat per cycle.
REQ-028 The capture strobe and a FIFO pop in the same cycle SHALL leave occupancy unchanged.

Reset
REQ-029 On rst_i all of the following SHALL hold from the next clock edge:
  - state = IDLE; FIFO empty; in-flight pipeline cleared.
  - busy_o, done_o, ram_en_o, ram_regce_o, m_valid_o and m_last_o = 0.
  - ram_addr_o = 0; m_data_o = 0.
REQ-030 Reset asserted mid-transfer SHALL abandon the transfer without a done_o pulse, and any RAM data returning afterwards SHALL be discarded.

Configuration
REQ-031 With macro BRAM_RD_ABORT_EN defined, an input abort_i (1 bit) SHALL exist; abort_i high in ISSUE or DRAIN SHALL:
  - stop issuing reads;
  - empty the FIFO and drop m_valid_o in the next cycle;
  - enter FLUSH for 2 cycles to discard in-flight data;
  - return to IDLE with no done_o pulse; busy_o stays high through FLUSH.
REQ-032 Without BRAM_RD_ABORT_EN, port abort_i and state FLUSH SHALL NOT exist.

Verification
REQ-033 base=3, len=4, m_ready_i=1 -> addresses 3,4,5,6 on cycles 1-4; beats RAM[3..6] on cycles 4-7; m_last_o on cycle 7; done_o on cycle 7.
REQ-034 base=14, len=4, ADDR_LINES=4 -> addresses 14,15,0,1; data order matches.
REQ-035 len=8, m_ready_i low for cycles 3-12 -> at most 4 reads outstanding; no beat lost or duplicated; all 8 beats in order after ready rises.
REQ-036 len=0 -> done_o pulse 1 cycle after start_i; ram_en_o and m_valid_o never high.
REQ-037 rst_i at cycle 5 of a len=10 transfer -> all outputs at reset values from cycle 6; no beats or done_o afterwards; a new start_i works normally.
REQ-038 BRAM_RD_ABORT_EN: abort_i at cycle 6 of len=10 -> m_valid_o low at cycle 7; busy_o low after FLUSH; no done_o pulse.

Source files
------------

// File: rtl/bram_stream_reader_if.sv
// Bus bundle for bram_stream_reader: the 2-cycle BRAM read port and the outgoing stream.
// master = reader side, slave = RAM/stream-sink side.
interface bram_stream_reader_if #(
   parameter int RAM_WIDTH  = 32,
   parameter int ADDR_LINES = 4
);
   logic                  ram_en_o;
   logic [ADDR_LINES-1:0] ram_addr_o;
   logic                  ram_regce_o;
   logic                  ram_rstn_o;
   logic [RAM_WIDTH-1:0]  ram_dout_i;

   logic                  m_valid_o;
   logic                  m_ready_i;
   logic [RAM_WIDTH-1:0]  m_data_o;
   logic                  m_last_o;

   modport master (
      output ram_en_o, ram_addr_o, ram_regce_o, ram_rstn_o,
      input  ram_dout_i,
      output m_valid_o, m_data_o, m_last_o,
      input  m_ready_i
   );

   modport slave (
      input  ram_en_o, ram_addr_o, ram_regce_o, ram_rstn_o,
      output ram_dout_i,
      input  m_valid_o, m_data_o, m_last_o,
      output m_ready_i
   );
endinterface

// File: rtl/bram_stream_reader.sv
// Streams len_i words from a 2-cycle-latency BRAM starting at base_addr_i, through a 4-entry
// credit-controlled FIFO. Define BRAM_RD_ABORT_EN to add abort_i and the FLUSH state.
module bram_stream_reader #(
   parameter int RAM_WIDTH  = 32,
   parameter int ADDR_LINES = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  start_i,
   input  logic [ADDR_LINES-1:0] base_addr_i,
   input  logic [ADDR_LINES:0]   len_i,
`ifdef BRAM_RD_ABORT_EN
   input  logic                  abort_i,
`endif
   output logic                  busy_o,
   output logic                  done_o,
   bram_stream_reader_if.master  bus
);

`ifdef BRAM_RD_ABORT_EN
   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FLUSH} state_t;
`else
   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
`endif

   localparam logic [ADDR_LINES:0]   LEN_ONE  = (ADDR_LINES+1)'(1);
   localparam logic [ADDR_LINES-1:0] ADDR_ONE = ADDR_LINES'(1);

   state_t                r_state, w_state_nxt;
   logic [ADDR_LINES-1:0] r_addr;
   logic [ADDR_LINES:0]   r_issue_left, r_beats_left;
   logic                  r_en_d1, r_en_d2, r_zero_done;
`ifdef BRAM_RD_ABORT_EN
   logic                  r_flush_cnt;
`endif

   logic [RAM_WIDTH-1:0]  r_fifo [4];
   logic [1:0]            r_wr_ptr, r_rd_ptr;
   logic [2:0]            r_count;

   logic                  w_abort, w_ram_en, w_capture, w_valid, w_beat, w_last_beat;
   logic [2:0]            w_inflight;

`ifdef BRAM_RD_ABORT_EN
   assign w_abort   = abort_i && (r_state == ISSUE || r_state == DRAIN);
   assign w_capture = r_en_d2 && (r_state != FLUSH);
`else
   assign w_abort   = 1'b0;
   assign w_capture = r_en_d2;
`endif

   // Reads still in the RAM pipeline count against FIFO space so returning data always fits.
   assign w_inflight  = {2'b00, r_en_d1} + {2'b00, r_en_d2} + r_count;
   assign w_ram_en    = (r_state == ISSUE) && (w_inflight < 3'd4) && !w_abort;
   assign w_valid     = (r_count != 3'd0);
   assign w_beat      = w_valid && bus.m_ready_i;
   assign w_last_beat = w_beat && (r_beats_left == LEN_ONE);

   assign busy_o = (r_state != IDLE);
   assign done_o = r_zero_done || ((r_state == DRAIN) && w_last_beat && !w_abort);

   assign bus.ram_en_o    = w_ram_en;
   assign bus.ram_addr_o  = r_addr;
   assign bus.ram_regce_o = r_en_d1;
   assign bus.ram_rstn_o  = ~rst_i;
   assign bus.m_valid_o   = w_valid;
   assign bus.m_last_o    = w_valid && (r_beats_left == LEN_ONE);
   assign bus.m_data_o    = w_valid ? r_fifo[r_rd_ptr] : '0;

   // NOTE: every always_comb output gets a default before the case, so no path can infer a latch.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:  if (start_i && (len_i != '0)) w_state_nxt = ISSUE;
         ISSUE: begin
            if (w_ram_en && (r_issue_left == LEN_ONE)) w_state_nxt = DRAIN;
`ifdef BRAM_RD_ABORT_EN
            if (w_abort) w_state_nxt = FLUSH;
`endif
         end
         DRAIN: begin
            if (w_last_beat) w_state_nxt = IDLE;
`ifdef BRAM_RD_ABORT_EN
            if (w_abort) w_state_nxt = FLUSH;
`endif
         end
`ifdef BRAM_RD_ABORT_EN
         FLUSH: if (r_flush_cnt) w_state_nxt = IDLE;
`endif
         default: w_state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state      <= IDLE;
         r_addr       <= '0;
         r_issue_left <= '0;
         r_beats_left <= '0;
         r_en_d1      <= 1'b0;
         r_en_d2      <= 1'b0;
         r_zero_done  <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_en_d1     <= w_ram_en;
         r_en_d2     <= r_en_d1;
         r_zero_done <= (r_state == IDLE) && start_i && (len_i == '0);
         if ((r_state == IDLE) && start_i) begin
            r_addr       <= base_addr_i;
            r_issue_left <= len_i;
            r_beats_left <= len_i;
         end else begin
            if (w_ram_en) begin
               r_addr       <= r_addr + ADDR_ONE;
               r_issue_left <= r_issue_left - LEN_ONE;
            end
            if (w_beat) r_beats_left <= r_beats_left - LEN_ONE;
         end
      end
   end

`ifdef BRAM_RD_ABORT_EN
   always_ff @(posedge clk_i) begin
      if (rst_i || r_state != FLUSH) r_flush_cnt <= 1'b0;
      else                           r_flush_cnt <= ~r_flush_cnt;
   end
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i || w_abort) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_capture) r_wr_ptr <= r_wr_ptr + 2'd1;
         if (w_beat)    r_rd_ptr <= r_rd_ptr + 2'd1;
         case ({w_capture, w_beat})
            2'b10:   r_count <= r_count + 3'd1;
            2'b01:   r_count <= r_count - 3'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   // NOTE: FIFO storage is left unreset; m_data_o is masked while empty so stale words never show.
   always_ff @(posedge clk_i) begin
      if (w_capture) r_fifo[r_wr_ptr] <= bus.ram_dout_i;
   end

endmodule

// File: tb/tb_bram_stream_reader.sv
// Self-checking bench for bram_stream_reader: behavioural 2-cycle BRAM plus a beat scoreboard.
// Abort scenario is compiled in when BRAM_RD_ABORT_EN is defined.
module tb_bram_stream_reader;
   localparam int RAM_WIDTH  = 32;
   localparam int ADDR_LINES = 4;
   localparam int DEPTH      = 16;

   typedef struct {
      logic [RAM_WIDTH-1:0] data;
      logic                 last;
   } beat_t;

   logic                  clk   = 1'b0;
   logic                  rst   = 1'b1;
   logic                  start = 1'b0;
   logic [ADDR_LINES-1:0] base  = '0;
   logic [ADDR_LINES:0]   len   = '0;
`ifdef BRAM_RD_ABORT_EN
   logic                  abort = 1'b0;
`endif
   logic                  busy, done;

   logic [RAM_WIDTH-1:0]  mem [DEPTH];
   logic [RAM_WIDTH-1:0]  ram_lat;
   beat_t                 sb [$];
   int                    n_checks = 0;
   int                    n_errors = 0;

   bram_stream_reader_if #(.RAM_WIDTH(RAM_WIDTH), .ADDR_LINES(ADDR_LINES)) bus ();

   bram_stream_reader #(.RAM_WIDTH(RAM_WIDTH), .ADDR_LINES(ADDR_LINES)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .start_i     (start),
      .base_addr_i (base),
      .len_i       (len),
`ifdef BRAM_RD_ABORT_EN
      .abort_i     (abort),
`endif
      .busy_o      (busy),
      .done_o      (done),
      .bus         (bus)
   );

   always #5 clk = ~clk;

   // 2-cycle BRAM: array read on en, output register loads on regce.
   always @(posedge clk) begin
      if (bus.ram_en_o) ram_lat <= mem[bus.ram_addr_o];
      if (!bus.ram_rstn_o)      bus.ram_dout_i <= '0;
      else if (bus.ram_regce_o) bus.ram_dout_i <= ram_lat;
   end

   // Scoreboard consumer: every handshake must match the next expected beat.
   always @(negedge clk) begin
      beat_t e;
      if (bus.m_valid_o === 1'b1 && bus.m_ready_i === 1'b1) begin
         n_checks++;
         if (sb.size() == 0) begin
            n_errors++;
            $display("FAIL beat_unexpected: got data %08h last %0b, expected no beat", bus.m_data_o, bus.m_last_o);
         end else begin
            e = sb.pop_front();
            if (bus.m_data_o !== e.data || bus.m_last_o !== e.last) begin
               n_errors++;
               $display("FAIL beat: got data %08h last %0b, expected data %08h last %0b",
                        bus.m_data_o, bus.m_last_o, e.data, e.last);
            end
         end
      end
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic push_expected(input logic [ADDR_LINES-1:0] b, input int n);
      beat_t x;
      for (int i = 0; i < n; i++) begin
         x.data = mem[ADDR_LINES'(b + i)];
         x.last = (i == n - 1);
         sb.push_back(x);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.m_ready_i = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if ({busy, done, bus.ram_en_o, bus.ram_regce_o, bus.m_valid_o, bus.m_last_o} !== 6'b0) begin
         n_errors++;
         $display("FAIL reset_ctrl: got %06b, expected 000000",
                  {busy, done, bus.ram_en_o, bus.ram_regce_o, bus.m_valid_o, bus.m_last_o});
      end
      n_checks++;
      if (bus.ram_addr_o !== '0) begin
         n_errors++; $display("FAIL reset_addr: got %0h, expected 0", bus.ram_addr_o);
      end
      n_checks++;
      if (bus.m_data_o !== '0) begin
         n_errors++; $display("FAIL reset_data: got %0h, expected 0", bus.m_data_o);
      end
      n_checks++;
      if (bus.ram_rstn_o !== 1'b0) begin
         n_errors++; $display("FAIL reset_rstn: got %0b, expected 0", bus.ram_rstn_o);
      end
      next_cycle();
      rst = 1'b0;
      next_cycle();
   endtask

   // base=3 len=4, ready high: exact cycle-by-cycle timing of reads, beats, last and done.
   task automatic test_basic();
      logic [ADDR_LINES-1:0] ea;
      bus.m_ready_i = 1'b1;
      push_expected(4'd3, 4);
      start = 1'b1; base = 4'd3; len = 5'd4;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         n_checks++;
         if (bus.ram_en_o !== (c >= 1 && c <= 4)) begin
            n_errors++; $display("FAIL basic_en c%0d: got %0b, expected %0b", c, bus.ram_en_o, (c >= 1 && c <= 4));
         end
         if (c >= 1 && c <= 4) begin
            ea = ADDR_LINES'(c + 2);
            n_checks++;
            if (bus.ram_addr_o !== ea) begin
               n_errors++; $display("FAIL basic_addr c%0d: got %0d, expected %0d", c, bus.ram_addr_o, ea);
            end
         end
         n_checks++;
         if (bus.m_valid_o !== (c >= 4 && c <= 7)) begin
            n_errors++; $display("FAIL basic_valid c%0d: got %0b, expected %0b", c, bus.m_valid_o, (c >= 4 && c <= 7));
         end
         n_checks++;
         if (bus.m_last_o !== (c == 7) || done !== (c == 7)) begin
            n_errors++; $display("FAIL basic_last_done c%0d: got last %0b done %0b, expected %0b", c, bus.m_last_o, done, (c == 7));
         end
         n_checks++;
         if (busy !== (c >= 1 && c <= 7)) begin
            n_errors++; $display("FAIL basic_busy c%0d: got %0b, expected %0b", c, busy, (c >= 1 && c <= 7));
         end
         next_cycle();
         start = 1'b0;
      end
      n_checks++;
      if (sb.size() != 0) begin
         n_errors++; $display("FAIL basic_sb_left: got %0d, expected 0", sb.size());
      end
   endtask

   // base=14 len=4 wraps through the top of the RAM.
   task automatic test_wrap();
      logic [ADDR_LINES-1:0] got [$];
      logic [ADDR_LINES-1:0] ea;
      bit seen = 0;
      bus.m_ready_i = 1'b1;
      push_expected(4'd14, 4);
      start = 1'b1; base = 4'd14; len = 5'd4;
      for (int c = 0; c < 30 && !seen; c++) begin
         @(negedge clk);
         if (bus.ram_en_o) got.push_back(bus.ram_addr_o);
         if (done) seen = 1;
         next_cycle();
         start = 1'b0;
      end
      n_checks++;
      if (!seen) begin
         n_errors++; $display("FAIL wrap_done_timeout: got no done, expected done");
      end
      n_checks++;
      if (got.size() != 4) begin
         n_errors++; $display("FAIL wrap_nreads: got %0d, expected 4", got.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            ea = ADDR_LINES'(14 + i);
            n_checks++;
            if (got[i] !== ea) begin
               n_errors++; $display("FAIL wrap_addr%0d: got %0d, expected %0d", i, got[i], ea);
            end
         end
      end
      n_checks++;
      if (sb.size() != 0) begin
         n_errors++; $display("FAIL wrap_sb_left: got %0d, expected 0", sb.size());
      end
   endtask

   // len=8 with ready low for cycles 3..12: credit limit, stall stability, nothing lost.
   task automatic test_backpressure();
      int iss = 0, pop = 0;
      bit seen = 0, prev_stall = 0;
      logic [RAM_WIDTH-1:0] prev_data = '0;
      push_expected(4'd5, 8);
      start = 1'b1; base = 4'd5; len = 5'd8;
      for (int c = 0; c < 60 && !seen; c++) begin
         bus.m_ready_i = !(c >= 3 && c <= 12);
         @(negedge clk);
         if (bus.ram_en_o) iss++;
         if (bus.m_valid_o && bus.m_ready_i) pop++;
         n_checks++;
         if (iss - pop > 4) begin
            n_errors++; $display("FAIL bp_outstanding c%0d: got %0d, expected <= 4", c, iss - pop);
         end
         if (prev_stall) begin
            n_checks++;
            if (bus.m_valid_o !== 1'b1 || bus.m_data_o !== prev_data) begin
               n_errors++; $display("FAIL bp_stable c%0d: got valid %0b data %08h, expected valid 1 data %08h",
                                    c, bus.m_valid_o, bus.m_data_o, prev_data);
            end
         end
         prev_stall = bus.m_valid_o && !bus.m_ready_i;
         prev_data  = bus.m_data_o;
         if (done) seen = 1;
         next_cycle();
         start = 1'b0;
      end
      bus.m_ready_i = 1'b1;
      n_checks++;
      if (!seen || pop != 8) begin
         n_errors++; $display("FAIL bp_complete: got done %0b beats %0d, expected done 1 beats 8", seen, pop);
      end
      n_checks++;
      if (sb.size() != 0) begin
         n_errors++; $display("FAIL bp_sb_left: got %0d, expected 0", sb.size());
      end
   endtask

   task automatic test_zero_len();
      bus.m_ready_i = 1'b1;
      start = 1'b1; base = 4'd9; len = 5'd0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         n_checks++;
         if ({bus.ram_en_o, bus.m_valid_o, busy} !== 3'b000 || done !== (c == 1)) begin
            n_errors++; $display("FAIL zero_len c%0d: got en %0b valid %0b busy %0b done %0b, expected done %0b only",
                                 c, bus.ram_en_o, bus.m_valid_o, busy, done, (c == 1));
         end
         next_cycle();
         start = 1'b0;
      end
   endtask

   // Reset at cycle 5 of a len=10 transfer: quiet afterwards, then a fresh transfer works.
   task automatic test_reset_mid();
      bus.m_ready_i = 1'b1;
      push_expected(4'd0, 10);
      start = 1'b1; base = 4'd0; len = 5'd10;
      for (int c = 0; c < 16; c++) begin
         if (c == 5) rst = 1'b1;
         if (c == 6) begin
            rst = 1'b0;
            sb.delete();
         end
         @(negedge clk);
         n_checks++;
         if (done !== 1'b0) begin
            n_errors++; $display("FAIL rstmid_done c%0d: got %0b, expected 0", c, done);
         end
         if (c == 5) begin
            n_checks++;
            if (bus.ram_rstn_o !== 1'b0) begin
               n_errors++; $display("FAIL rstmid_rstn: got %0b, expected 0", bus.ram_rstn_o);
            end
         end
         if (c >= 6) begin
            n_checks++;
            if ({busy, bus.ram_en_o, bus.ram_regce_o, bus.m_valid_o, bus.m_last_o} !== 5'b0 ||
                bus.ram_addr_o !== '0 || bus.m_data_o !== '0) begin
               n_errors++; $display("FAIL rstmid_quiet c%0d: got ctrl %05b addr %0h data %0h, expected all 0", c,
                                    {busy, bus.ram_en_o, bus.ram_regce_o, bus.m_valid_o, bus.m_last_o},
                                    bus.ram_addr_o, bus.m_data_o);
            end
         end
         next_cycle();
         start = 1'b0;
      end
      test_basic();
   endtask

`ifdef BRAM_RD_ABORT_EN
   // abort at cycle 6 of len=10: valid drops at 7, FLUSH 7..8, idle at 9, no done.
   task automatic test_abort();
      bus.m_ready_i = 1'b1;
      push_expected(4'd2, 10);
      start = 1'b1; base = 4'd2; len = 5'd10;
      for (int c = 0; c < 15; c++) begin
         if (c == 6) abort = 1'b1;
         if (c == 7) begin
            abort = 1'b0;
            sb.delete();
         end
         @(negedge clk);
         n_checks++;
         if (done !== 1'b0 || busy !== (c >= 1 && c <= 8)) begin
            n_errors++; $display("FAIL abort_done_busy c%0d: got done %0b busy %0b, expected done 0 busy %0b",
                                 c, done, busy, (c >= 1 && c <= 8));
         end
         if (c >= 6) begin
            n_checks++;
            if (bus.ram_en_o !== 1'b0) begin
               n_errors++; $display("FAIL abort_en c%0d: got %0b, expected 0", c, bus.ram_en_o);
            end
         end
         if (c >= 7) begin
            n_checks++;
            if (bus.m_valid_o !== 1'b0) begin
               n_errors++; $display("FAIL abort_valid c%0d: got %0b, expected 0", c, bus.m_valid_o);
            end
         end
         next_cycle();
         start = 1'b0;
      end
      test_wrap();
   endtask
`endif

   initial begin
      for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
      test_reset();
      test_basic();
      test_wrap();
      test_backpressure();
      test_zero_len();
      test_reset_mid();
`ifdef BRAM_RD_ABORT_EN
      test_abort();
`endif
      repeat (3) next_cycle();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1, "watchdog");
   end

endmodule
